// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and state encoding for the truth-table sweep controller.
package truth_table_sweeper_pkg;

   localparam int unsigned VEC_W = 5;
   localparam int unsigned N_VEC = 32;
   localparam int unsigned CNT_W = 6;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t DRIVE  = 2'd1;
   localparam state_t SAMPLE = 2'd2;
   localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/truth_table_sweeper.sv
// Drives all 32 five-bit vectors into a combinational block, samples its output
// after a settle time, and compares the collected truth table against a golden one.
module truth_table_sweeper
   import truth_table_sweeper_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N_VEC-1:0]  expected,
   input  logic              o_p,
   output logic              a,
   output logic              b,
   output logic              c,
   output logic              d,
   output logic              e,
   output logic              busy,
   output logic              done,
   output logic [N_VEC-1:0]  truth_table,
   output logic [CNT_W-1:0]  ones_count,
   output logic              mismatch,
   output logic [VEC_W-1:0]  first_fail_idx
);

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(N_VEC - 1);

   state_t             state;
   logic [VEC_W-1:0]   idx;
   logic [3:0]         settle_cnt;
   logic [N_VEC-1:0]   exp_q;
   logic               sample_fail;

   assign sample_fail = (o_p != exp_q[idx]);

   // The stimulus is the registered index itself, so it only moves on SAMPLE exit.
   assign {a, b, c, d, e} = idx;
   assign busy = (state == DRIVE) || (state == SAMPLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         settle_cnt     <= '0;
         exp_q          <= '0;
         truth_table    <= '0;
         ones_count     <= '0;
         mismatch       <= 1'b0;
         first_fail_idx <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  exp_q          <= expected;
                  truth_table    <= '0;
                  ones_count     <= '0;
                  mismatch       <= 1'b0;
                  first_fail_idx <= '0;
                  idx            <= '0;
                  settle_cnt     <= '0;
                  state          <= DRIVE;
               end
            end
            DRIVE: begin
               settle_cnt <= settle_cnt + 4'd1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               truth_table[idx] <= o_p;
               ones_count       <= ones_count + CNT_W'(o_p);
               if (sample_fail && !mismatch) begin
                  mismatch       <= 1'b1;
                  first_fail_idx <= idx;
               end
               if (idx == LAST_VEC) begin
                  state <= DONE;
               end else begin
                  idx        <= idx + VEC_W'(1);
                  settle_cnt <= '0;
                  state      <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: two sweepers (settle 1 and 3) checked every cycle against a timeline model.
module tb_truth_table_sweeper;
   import truth_table_sweeper_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] expected = '0;
   int          mode = 0;
   logic [31:0] rtbl = '0;

   always #5 clk = ~clk;

   logic        a1, b1, c1, d1, e1, busy1, done1, mm1, op1;
   logic [31:0] tt1;
   logic [5:0]  oc1;
   logic [4:0]  ff1, vec1;
   logic        a3, b3, c3, d3, e3, busy3, done3, mm3, op3;
   logic [31:0] tt3;
   logic [5:0]  oc3;
   logic [4:0]  ff3, vec3;

   // Stand-ins for the block under test: stuck-0, 5-input AND, 5-input XOR, arbitrary table.
   function automatic logic ref_fn(int m, logic [4:0] v, logic [31:0] rt);
      case (m)
         0:       return 1'b0;
         1:       return &v;
         2:       return ^v;
         default: return rt[v];
      endcase
   endfunction

   function automatic logic [31:0] ref_table(int m, logic [31:0] rt);
      logic [31:0] t = '0;
      for (int i = 0; i < 32; i++) t[i] = ref_fn(m, 5'(i), rt);
      return t;
   endfunction

   function automatic logic [4:0] first_diff(logic [31:0] x);
      for (int i = 0; i < 32; i++) if (x[i]) return 5'(i);
      return 5'd0;
   endfunction

   assign vec1 = {a1, b1, c1, d1, e1};
   assign vec3 = {a3, b3, c3, d3, e3};
   assign op1  = ref_fn(mode, vec1, rtbl);
   assign op3  = ref_fn(mode, vec3, rtbl);

   truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .o_p(op1),
      .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .busy(busy1), .done(done1),
      .truth_table(tt1), .ones_count(oc1), .mismatch(mm1), .first_fail_idx(ff1)
   );

   truth_table_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .o_p(op3),
      .a(a3), .b(b3), .c(c3), .d(d3), .e(e3), .busy(busy3), .done(done3),
      .truth_table(tt3), .ones_count(oc3), .mismatch(mm3), .first_fail_idx(ff3)
   );

   int checks = 0;
   int passes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   // Model: a sweep is just "n cycles since acceptance"; vector = n/(S+1), done at 32*(S+1).
   bit          act1 = 1'b0, act3 = 1'b0;
   int          n1 = 0, n3 = 0;
   logic [31:0] rtt1 = '0, rexp1 = '0, rtt3 = '0, rexp3 = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act1 <= 1'b0; act3 <= 1'b0; n1 <= 0; n3 <= 0;
      end else begin
         if (start && (!act1 || n1 >= 64)) begin
            act1 <= 1'b1; n1 <= 0; rtt1 <= ref_table(mode, rtbl); rexp1 <= expected;
         end else if (act1 && n1 < 64) n1 <= n1 + 1;
         if (start && (!act3 || n3 >= 128)) begin
            act3 <= 1'b1; n3 <= 0; rtt3 <= ref_table(mode, rtbl); rexp3 <= expected;
         end else if (act3 && n3 < 128) n3 <= n3 + 1;
      end
   end

   task automatic model_check(input string tag, input bit act, input int n, input int s,
                              input logic [31:0] rtt, input logic [31:0] rexp,
                              input logic [4:0] v, input logic bsy, input logic dn,
                              input logic [31:0] tt, input logic [5:0] oc,
                              input logic mm, input logic [4:0] ff);
      int len = 32 * (s + 1);
      if (!act) begin
         check({tag, "_idle_vec"}, 32'(v), 0);
         check({tag, "_idle_busy"}, 32'(bsy), 0);
         check({tag, "_idle_done"}, 32'(dn), 0);
         check({tag, "_idle_tt"}, tt, 0);
         check({tag, "_idle_ones"}, 32'(oc), 0);
         check({tag, "_idle_mm"}, 32'(mm), 0);
         check({tag, "_idle_ff"}, 32'(ff), 0);
      end else if (n < len) begin
         check({tag, "_vec"}, 32'(v), 32'(n / (s + 1)));
         check({tag, "_busy"}, 32'(bsy), 1);
         check({tag, "_done"}, 32'(dn), 0);
      end else begin
         check({tag, "_end_vec"}, 32'(v), 31);
         check({tag, "_end_busy"}, 32'(bsy), 0);
         check({tag, "_end_done"}, 32'(dn), 1);
         check({tag, "_tt"}, tt, rtt);
         check({tag, "_ones"}, 32'(oc), 32'($countones(rtt)));
         check({tag, "_mm"}, 32'(mm), 32'(rtt != rexp));
         check({tag, "_ff"}, 32'(ff), 32'(first_diff(rtt ^ rexp)));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         model_check("s1", act1, n1, 1, rtt1, rexp1, vec1, busy1, done1, tt1, oc1, mm1, ff1);
         model_check("s3", act3, n3, 3, rtt3, rexp3, vec3, busy3, done3, tt3, oc3, mm3, ff3);
      end
   end

   task automatic wait_done(output int cy1, output int cy3);
      cy1 = 0; cy3 = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (done1 && cy1 == 0) cy1 = i;
         if (done3 && cy3 == 0) cy3 = i;
         if (done1 && done3) break;
      end
      check("done_within_bound", 32'(done1 && done3), 1);
   endtask

   task automatic sweep(input int m, input logic [31:0] ex, output int cy1, output int cy3);
      mode = m;
      @(negedge clk);
      expected = ex;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cy1, cy3);
   endtask

   task automatic launch(input int m, input logic [31:0] ex);
      mode = m;
      @(negedge clk);
      expected = ex;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_vec1(input logic [4:0] target);
      bit hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (vec1 == target) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      check("reach_vector", 32'(hit), 1);
   endtask

   initial begin
      int cy1, cy3;
      logic [31:0] ex;

      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      sweep(0, 32'h0, cy1, cy3);
      check("stuck0_tt", tt1, 32'h0);
      check("stuck0_ones", 32'(oc1), 0);
      check("stuck0_mm", 32'(mm1), 0);
      check("sweep_len_s1", 32'(cy1), 64);
      check("sweep_len_s3", 32'(cy3), 128);

      sweep(1, 32'h8000_0000, cy1, cy3);
      check("and_tt", tt1, 32'h8000_0000);
      check("and_ones", 32'(oc1), 1);
      check("and_mm", 32'(mm1), 0);

      sweep(2, 32'h9669_6996, cy1, cy3);
      check("xor_tt", tt1, 32'h9669_6996);
      check("xor_ones", 32'(oc1), 16);
      check("xor_mm", 32'(mm1), 0);

      sweep(2, 32'h9669_6997, cy1, cy3);
      check("xor_bad_mm", 32'(mm1), 1);
      check("xor_bad_ff", 32'(ff1), 0);
      check("xor_bad_mm_s3", 32'(mm3), 1);

      rtbl = 32'hFFFF_FFFF;
      sweep(3, 32'hFFFF_FFFF, cy1, cy3);
      check("all_ones_count", 32'(oc1), 32);

      for (int k = 0; k < 4; k++) begin
         rtbl = $urandom;
         ex = rtbl;
         if (k == 1) ex = rtbl ^ (32'h1 << $urandom_range(31, 0));
         if (k == 3) ex = rtbl ^ $urandom;
         sweep(3, ex, cy1, cy3);
      end

      // start pulsed mid-sweep with a different golden table must be ignored
      rtbl = $urandom;
      launch(3, rtbl);
      wait_vec1(5'd10);
      expected = ~rtbl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cy1, cy3);
      check("midstart_tt", tt1, rtbl);
      check("midstart_mm", 32'(mm1), 0);

      // asynchronous reset mid-sweep clears everything before any clock edge
      rtbl = $urandom;
      launch(3, rtbl);
      wait_vec1(5'd17);
      #2 rst_n = 1'b0;
      #1;
      check("rst_vec1", 32'(vec1), 0);
      check("rst_busy1", 32'(busy1), 0);
      check("rst_tt1", tt1, 0);
      check("rst_ones1", 32'(oc1), 0);
      check("rst_busy3", 32'(busy3), 0);
      check("rst_vec3", 32'(vec3), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      rtbl = $urandom;
      sweep(3, rtbl ^ 32'h0001_0000, cy1, cy3);
      check("post_rst_tt", tt1, rtbl);
      check("post_rst_ff", 32'(ff1), 16);
      check("post_rst_len", 32'(cy1), 64);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
